upower_decode_stage: RTL and testbench
======================================

// Module: upower_decode_stage
// PURPOSE
//  Decode/issue stage feeding the 64-bit uPower ALU: accepts 32-bit instructions + PC via valid/ready,
//  splits them into ALU field ports (opcode, rs, rt, rb, bo, bi, si, ds, xox, xoxo, aa, xods) and
//  flags illegal encodings. Registered output with a 1-entry skid buffer gives full throughput under
//  backpressure. Fields outside the decoded format are driven 0, so the ALU's xoxo/xox/si/ds != 0 priority selects correctly.
// PARAMETERS
//  PC_W   64  width of PC carried alongside each instruction
//  CNT_W  16  width of perf counters (DECODE_PERF_EN only)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      async active-low reset
//  flush        in   1      sync pipeline flush (branch redirect)
//  in_valid     in   1      instruction valid
//  in_ready     out  1      stage can accept (= ~skid_valid)
//  in_instr     in   32     instruction word, bit 31 = MSB of opcode
//  in_pc        in   PC_W   instruction PC
//  out_valid    out  1      decoded bundle valid
//  out_ready    in   1      ALU/execute accepts bundle
//  out_pc       out  PC_W   PC of bundle
//  opcode       out  6      instr[31:26]
//  rs, bo       out  5      instr[25:21] (rs: X/XO/D/DS; bo: B only)
//  rt, bi       out  5      instr[20:16] (rt: X/XO/D/DS; bi: B only)
//  rb           out  5      instr[15:11], X/XO only
//  si           out  16     instr[15:0], D and B formats
//  ds           out  14     instr[15:2], DS only
//  xods         out  2      instr[1:0], DS only
//  xox          out  10     instr[10:1], X only
//  xoxo         out  9      instr[9:1], XO only
//  aa           out  1      instr[1], B and I only
//  illegal      out  1      bundle is an undefined encoding; all fields except opcode = 0
// BEHAVIOUR
//  - Reset: out_valid=0, skid_valid=0, all field outputs/out_pc/illegal=0; in_ready=1 after release.
//  - Format decode (combinational on input, registered into output/skid):
//    XO: op 31 and instr[9:1] in {266,40}; X: op 31 and instr[10:1] in {28,476,444,316,986};
//    D: op in {14,15,24,26,28,32,34,36,37,38,40,42,44}; DS: op in {58,62}; B: op 19; I: op 18.
//    XO checked before X. Anything else -> illegal=1.
//  - Handshake: in fire = in_valid & in_ready; out fire = out_valid & out_ready. Latency 1 cycle.
//    Output empty or firing: input (or skid if occupied, skid first) loads output register.
//    Output stalled and in fire: bundle into skid; in_ready drops next cycle.
//    Skid drains into output on next out fire; order strictly preserved; no bundle dropped or duplicated.
//  - out_* stable while out_valid & ~out_ready.
//  - flush: next edge clears out_valid and skid_valid; input offered that cycle is dropped even if in_valid & in_ready.
//    flush overrides simultaneous in/out fires.
//  - Async reset mid-stream discards all held bundles immediately.
// CONFIGURATION
//  DECODE_PERF_EN defined: adds outputs perf_decoded [CNT_W] (++ per out fire) and perf_illegal [CNT_W]
//    (++ per out fire with illegal=1); saturate at all-ones; reset 0; not cleared by flush.
//  Undefined: ports and counters absent; datapath identical.
// TESTING
//  1 ADD 32'h7C642A14, out_ready=1 -> next cycle out_valid, opcode 31, rs 3, rt 4, rb 5, xoxo 266, xox 0, si 0.
//  2 ADDI 32'h382203E8 -> opcode 14, rs 1, rt 2, si 1000, xox 0, xoxo 0, ds 0, illegal 0.
//  3 32'h04000000 -> illegal 1, opcode 1, other fields 0; with DECODE_PERF_EN perf_illegal 1.
//  4 out_ready=0, 3 back-to-back instrs -> 2nd into skid, in_ready low; 3rd held;
//    release -> all 3 delivered in order, 1 per cycle.
//  5 flush with output and skid full plus in_valid -> next cycle out_valid 0, in_ready 1; none emerge.
//  6 rst_n low mid-stall -> out_valid 0 asynchronously; fields 0; in_ready 1 after release.

Source files
------------

// File: rtl/upower_decode_if.sv
// Handshake and decoded-field bundle between fetch, the decode stage and the uPower ALU.
// Slave side is the decode stage; master side is the surrounding pipeline.
interface upower_decode_if #(parameter int PC_W = 64);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [PC_W-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [PC_W-1:0] out_pc;
   logic [5:0]      opcode;
   logic [4:0]      rs;
   logic [4:0]      rt;
   logic [4:0]      rb;
   logic [4:0]      bo;
   logic [4:0]      bi;
   logic [15:0]     si;
   logic [13:0]     ds;
   logic [1:0]      xods;
   logic [9:0]      xox;
   logic [8:0]      xoxo;
   logic            aa;
   logic            illegal;

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, opcode, rs, rt, rb, bo, bi,
             si, ds, xods, xox, xoxo, aa, illegal
   );

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, opcode, rs, rt, rb, bo, bi,
             si, ds, xods, xox, xoxo, aa, illegal
   );
endinterface

// File: rtl/upower_decode_stage.sv
// uPower decode/issue stage: splits instructions into ALU field ports behind a registered skid buffer.
// Optional DECODE_PERF_EN adds saturating decoded/illegal bundle counters.
module upower_decode_stage #(
   parameter int PC_W = 64
`ifdef DECODE_PERF_EN
   ,
   parameter int CNT_W = 16
`endif
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   upower_decode_if.slave bus
`ifdef DECODE_PERF_EN
   ,
   output logic [CNT_W-1:0] perf_decoded,
   output logic [CNT_W-1:0] perf_illegal
`endif
);

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [5:0]      opcode;
      logic [4:0]      rs;
      logic [4:0]      rt;
      logic [4:0]      rb;
      logic [4:0]      bo;
      logic [4:0]      bi;
      logic [15:0]     si;
      logic [13:0]     ds;
      logic [1:0]      xods;
      logic [9:0]      xox;
      logic [8:0]      xoxo;
      logic            aa;
      logic            illegal;
   } bundle_t;

   function automatic logic is_d_op(input logic [5:0] op);
      case (op)
         6'd14, 6'd15, 6'd24, 6'd26, 6'd28, 6'd32, 6'd34,
         6'd36, 6'd37, 6'd38, 6'd40, 6'd42, 6'd44: is_d_op = 1'b1;
         default:                                  is_d_op = 1'b0;
      endcase
   endfunction

   function automatic logic is_x_xo(input logic [9:0] xo);
      case (xo)
         10'd28, 10'd476, 10'd444, 10'd316, 10'd986: is_x_xo = 1'b1;
         default:                                    is_x_xo = 1'b0;
      endcase
   endfunction

   // Unused fields stay zero so the ALU's xoxo/xox/si/ds priority picks the right operation.
   function automatic bundle_t decode(input logic [31:0] instr, input logic [PC_W-1:0] pc);
      bundle_t    b;
      logic [5:0] op;
      op       = instr[31:26];
      b        = '0;
      b.pc     = pc;
      b.opcode = op;
      if (op == 6'd31 && (instr[9:1] == 9'd266 || instr[9:1] == 9'd40)) begin
         b.rs   = instr[25:21];
         b.rt   = instr[20:16];
         b.rb   = instr[15:11];
         b.xoxo = instr[9:1];
      end else if (op == 6'd31 && is_x_xo(instr[10:1])) begin
         b.rs  = instr[25:21];
         b.rt  = instr[20:16];
         b.rb  = instr[15:11];
         b.xox = instr[10:1];
      end else if (is_d_op(op)) begin
         b.rs = instr[25:21];
         b.rt = instr[20:16];
         b.si = instr[15:0];
      end else if (op == 6'd58 || op == 6'd62) begin
         b.rs   = instr[25:21];
         b.rt   = instr[20:16];
         b.ds   = instr[15:2];
         b.xods = instr[1:0];
      end else if (op == 6'd19) begin
         b.bo = instr[25:21];
         b.bi = instr[20:16];
         b.si = instr[15:0];
         b.aa = instr[1];
      end else if (op == 6'd18) begin
         b.aa = instr[1];
      end else begin
         b.illegal = 1'b1;
      end
      return b;
   endfunction

   bundle_t dec_p0;
   bundle_t out_p1;
   bundle_t skid_p1;
   logic    vld_p1;
   logic    skid_vld_p1;
   logic    in_fire;
   logic    out_fire;

   // Stage 0: combinational decode of the offered instruction
   always_comb begin
      dec_p0 = decode(bus.in_instr, bus.in_pc);
   end

   assign bus.in_ready = ~skid_vld_p1;
   assign in_fire      = bus.in_valid & ~skid_vld_p1;
   assign out_fire     = vld_p1 & bus.out_ready;

   // Stage 1: output register backed by a one-entry skid buffer; skid always drains first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_p1      <= '0;
         skid_p1     <= '0;
         vld_p1      <= 1'b0;
         skid_vld_p1 <= 1'b0;
      end else if (flush) begin
         vld_p1      <= 1'b0;
         skid_vld_p1 <= 1'b0;
      end else if (!vld_p1 || out_fire) begin
         if (skid_vld_p1) begin
            out_p1      <= skid_p1;
            vld_p1      <= 1'b1;
            skid_vld_p1 <= 1'b0;
         end else begin
            vld_p1 <= in_fire;
            if (in_fire) out_p1 <= dec_p0;
         end
      end else if (in_fire) begin
         skid_p1     <= dec_p0;
         skid_vld_p1 <= 1'b1;
      end
   end

   assign bus.out_valid = vld_p1;
   assign bus.out_pc    = out_p1.pc;
   assign bus.opcode    = out_p1.opcode;
   assign bus.rs        = out_p1.rs;
   assign bus.rt        = out_p1.rt;
   assign bus.rb        = out_p1.rb;
   assign bus.bo        = out_p1.bo;
   assign bus.bi        = out_p1.bi;
   assign bus.si        = out_p1.si;
   assign bus.ds        = out_p1.ds;
   assign bus.xods      = out_p1.xods;
   assign bus.xox       = out_p1.xox;
   assign bus.xoxo      = out_p1.xoxo;
   assign bus.aa        = out_p1.aa;
   assign bus.illegal   = out_p1.illegal;

`ifdef DECODE_PERF_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   // Counters track bundles accepted downstream and survive flushes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_decoded <= '0;
         perf_illegal <= '0;
      end else if (out_fire) begin
         perf_decoded <= sat_inc(perf_decoded);
         if (out_p1.illegal) perf_illegal <= sat_inc(perf_illegal);
      end
   end
`endif

endmodule

// File: tb/tb_upower_decode_stage.sv
// Scoreboard bench for upower_decode_stage: directed instruction vectors, skid, flush and reset cases.
module tb_upower_decode_stage;
   typedef struct packed {
      logic [63:0] pc;
      logic [5:0]  opcode;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rb;
      logic [4:0]  bo;
      logic [4:0]  bi;
      logic [15:0] si;
      logic [13:0] ds;
      logic [1:0]  xods;
      logic [9:0]  xox;
      logic [8:0]  xoxo;
      logic        aa;
      logic        illegal;
   } exp_t;

   logic clk;
   logic rst_n;
   logic flush;
   int   total;
   int   bad;
   exp_t q[$];
   exp_t act_m;
   exp_t exp_m;

   upower_decode_if #(.PC_W(64)) bus();

`ifdef DECODE_PERF_EN
   logic [15:0] perf_decoded;
   logic [15:0] perf_illegal;
`endif

   upower_decode_stage #(.PC_W(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
`ifdef DECODE_PERF_EN
      ,
      .perf_decoded (perf_decoded),
      .perf_illegal (perf_illegal)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout req=finish");
      $fatal(1, "watchdog");
   end

   function automatic exp_t mk(input logic [63:0] pc, input int op, input int rs, input int rt,
                               input int rb, input int bo, input int bi, input int si, input int ds,
                               input int xods, input int xox, input int xoxo, input int aa,
                               input int ill);
      exp_t e;
      e.pc = pc;           e.opcode = 6'(op);   e.rs = 5'(rs);     e.rt = 5'(rt);
      e.rb = 5'(rb);       e.bo = 5'(bo);       e.bi = 5'(bi);     e.si = 16'(si);
      e.ds = 14'(ds);      e.xods = 2'(xods);   e.xox = 10'(xox);  e.xoxo = 9'(xoxo);
      e.aa = 1'(aa);       e.illegal = 1'(ill);
      return e;
   endfunction

   // Monitor: every accepted output bundle is popped from the scoreboard and compared
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         act_m = {bus.out_pc, bus.opcode, bus.rs, bus.rt, bus.rb, bus.bo, bus.bi, bus.si,
                  bus.ds, bus.xods, bus.xox, bus.xoxo, bus.aa, bus.illegal};
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_bundle act=%h req=none", act_m);
         end else begin
            exp_m = q.pop_front();
            if (act_m !== exp_m) begin
               bad++;
               $display("FAIL bundle_pc_%0h act=%h req=%h", exp_m.pc, act_m, exp_m);
            end
         end
      end
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s act=%0h req=%0h", nm, act, req);
      end
   endtask

   task automatic check_fields_zero(input string nm);
      check(nm, 64'(|{bus.out_pc, bus.opcode, bus.rs, bus.rt, bus.rb, bus.bo, bus.bi, bus.si,
                      bus.ds, bus.xods, bus.xox, bus.xoxo, bus.aa, bus.illegal}), 64'd0);
   endtask

   // Called just after a rising edge; returns just after the edge that accepted the bundle
   task automatic send(input logic [31:0] instr, input exp_t e);
      bit acc;
      acc          = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_instr = instr;
      bus.in_pc    = e.pc;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (bus.in_ready && !flush) begin
            q.push_back(e);
            acc = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!acc) begin
         total++;
         bad++;
         $display("FAIL send_timeout act=no_accept req=accept pc=%0h", e.pc);
      end else begin
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string nm);
      bit done;
      done = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL %s act=%0d_pending req=0_pending", nm, q.size());
      end
      @(posedge clk);
      #1;
   endtask

   exp_t e_add, e_addi, e_ill, e_addo, e_and, e_x986, e_ill31, e_ld, e_bc, e_b, e_lwz;
   exp_t s_a, s_b, s_c;

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      flush = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_instr  = '0;
      bus.in_pc     = '0;
      bus.out_ready = 1'b1;

      //            pc        op  rs rt rb bo bi si      ds xods xox xoxo aa ill
      e_add   = mk(64'h1000, 31, 3, 4, 5, 0, 0, 0,      0, 0,   0,  266, 0, 0);
      e_addi  = mk(64'h1004, 14, 1, 2, 0, 0, 0, 1000,   0, 0,   0,  0,   0, 0);
      e_ill   = mk(64'h1008, 1,  0, 0, 0, 0, 0, 0,      0, 0,   0,  0,   0, 1);
      e_addo  = mk(64'h100C, 31, 3, 4, 5, 0, 0, 0,      0, 0,   0,  266, 0, 0);
      e_and   = mk(64'h1010, 31, 6, 7, 8, 0, 0, 0,      0, 0,   28, 0,   0, 0);
      e_x986  = mk(64'h1014, 31, 1, 0, 0, 0, 0, 0,      0, 0,  986, 0,   0, 0);
      e_ill31 = mk(64'h1018, 31, 0, 0, 0, 0, 0, 0,      0, 0,   0,  0,   0, 1);
      e_ld    = mk(64'h101C, 58, 3, 4, 0, 0, 0, 0,      5, 1,   0,  0,   0, 0);
      e_bc    = mk(64'h1020, 19, 0, 0, 0, 20, 2, 16'h12, 0, 0,  0,  0,   1, 0);
      e_b     = mk(64'h1024, 18, 0, 0, 0, 0, 0, 0,      0, 0,   0,  0,   1, 0);
      e_lwz   = mk(64'h1028, 32, 5, 6, 0, 0, 0, 16'hFFFC, 0, 0, 0,  0,   0, 0);

      #12;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check_fields_zero("rst_fields");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

      // All formats back to back, no backpressure
      send(32'h7C642A14, e_add);
      send(32'h382203E8, e_addi);
      send(32'h04000000, e_ill);
      send(32'h7C642E14, e_addo);
      send(32'h7CC74038, e_and);
      send(32'h7C2007B4, e_x986);
      send(32'h7C000002, e_ill31);
      send(32'hE8640015, e_ld);
      send(32'h4E820012, e_bc);
      send(32'h48000102, e_b);
      send(32'h80A6FFFC, e_lwz);
      wait_drain("drain_formats");
`ifdef DECODE_PERF_EN
      check("perf_decoded", 64'(perf_decoded), 64'd11);
      check("perf_illegal", 64'(perf_illegal), 64'd2);
`endif

      // Stall: output + skid fill, third instruction held, then burst release
      s_a = e_addi; s_a.pc = 64'h2000;
      s_b = e_and;  s_b.pc = 64'h2004;
      s_c = e_ill;  s_c.pc = 64'h2008;
      bus.out_ready = 1'b0;
      send(32'h382203E8, s_a);
      send(32'h7CC74038, s_b);
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h04000000;
      bus.in_pc    = 64'h2008;
      repeat (2) begin
         @(negedge clk);
         check("stall_in_ready", 64'(bus.in_ready), 64'd0);
         check("stall_out_valid", 64'(bus.out_valid), 64'd1);
         check("stall_out_pc", bus.out_pc, 64'h2000);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      fork
         send(32'h04000000, s_c);
         begin
            repeat (3) begin
               @(negedge clk);
               check("burst_out_valid", 64'(bus.out_valid), 64'd1);
            end
         end
      join
      wait_drain("drain_skid");

      // Flush with output and skid occupied and input offered
      bus.out_ready = 1'b0;
      s_a.pc = 64'h3000;
      s_b.pc = 64'h3004;
      send(32'h382203E8, s_a);
      send(32'h7CC74038, s_b);
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h7C642A14;
      bus.in_pc    = 64'h3008;
      flush        = 1'b1;
      @(posedge clk);
      #1;
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      q.delete();
      check("flush_out_valid", 64'(bus.out_valid), 64'd0);
      check("flush_in_ready", 64'(bus.in_ready), 64'd1);
      // Flush must also drop an input that would otherwise be accepted
      bus.in_valid = 1'b1;
      bus.in_pc    = 64'h300C;
      flush        = 1'b1;
      @(posedge clk);
      #1;
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("flush_no_emerge", 64'(bus.out_valid), 64'd0);
      end
      @(posedge clk);
      #1;

      // Asynchronous reset in the middle of a stall
      bus.out_ready = 1'b0;
      s_a.pc = 64'h4000;
      s_b.pc = 64'h4004;
      send(32'h382203E8, s_a);
      send(32'h7CC74038, s_b);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
      check_fields_zero("async_rst_fields");
      q.delete();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rerun_in_ready", 64'(bus.in_ready), 64'd1);
      bus.out_ready = 1'b1;
      s_a.pc = 64'h5000;
      send(32'h382203E8, s_a);
      wait_drain("drain_after_reset");
      check("final_out_valid", 64'(bus.out_valid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
